// File: rtl/seq_pkg.sv
// seq_pkg: shared state encodings and default frame pattern for the serial generator/detector pair
package seq_pkg;
    localparam int SEQ_PAT_W = 8;
    localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 8'b10101011;
    typedef enum logic [1:0] {IDLE = 2'd0, PAT = 2'd1, GAP = 2'd2} state_e;
endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: control and serial-stream bundle of seq_gen
//   master (driver): start, abort, repeat_cnt[CNT_W], gap[GAP_W], pat_in[SEQ_PAT_W] (only with SEQ_GEN_PROG_PAT_EN)
//   slave  (seq_gen): d_out, valid, frame_end, busy, done
interface seq_gen_if import seq_pkg::*; #(parameter int CNT_W = 8, parameter int GAP_W = 4) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
`ifdef SEQ_GEN_PROG_PAT_EN
    logic [SEQ_PAT_W-1:0] pat_in;
`endif
    logic d_out;
    logic valid;
    logic frame_end;
    logic busy;
    logic done;
    modport master(
`ifdef SEQ_GEN_PROG_PAT_EN
        output pat_in,
`endif
        output start, abort, repeat_cnt, gap,
        input  d_out, valid, frame_end, busy, done
    );
    modport slave(
`ifdef SEQ_GEN_PROG_PAT_EN
        input  pat_in,
`endif
        input  start, abort, repeat_cnt, gap,
        output d_out, valid, frame_end, busy, done
    );
endinterface

// File: rtl/seq_shift.sv
// seq_shift: loadable PISO shift register, MSB first
//   clk, rst_n : clock, async active-low reset
//   load, din  : parallel load (has priority over shift)
//   shift      : shift one place toward the MSB
//   msb        : MSB of the value being captured this edge, lined up with the D_OUT flop input
module seq_shift #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] sr_q, sr_d;
    always_comb sr_d = load ? din : shift ? {sr_q[W-2:0], 1'b0} : sr_q;
    assign msb = sr_d[W-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end
endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial frame generator, PAT_W-bit pattern MSB first with repeat count and zero-filled gaps
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_gen_if.slave (start/abort/repeat_cnt/gap in; d_out/valid/frame_end/busy/done out)
//   SEQ_GEN_PROG_PAT_EN: pattern taken from bus.pat_in at accepted start instead of PATTERN
module seq_gen import seq_pkg::*; #(
    parameter int             PAT_W   = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
    parameter int             CNT_W   = 8,
    parameter int             GAP_W   = 4
) (
    input logic       clk,
    input logic       rst_n,
    seq_gen_if.slave  bus
);
    localparam int IDX_W = $clog2(PAT_W);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic             load, shift, msb;
    logic [PAT_W-1:0] pat_src;
    logic d_out_q, d_out_d, valid_q, valid_d, fe_q, fe_d, done_q, done_d;
`ifdef SEQ_GEN_PROG_PAT_EN
    logic [PAT_W-1:0] pat_q, pat_d;
    // In IDLE the first frame is loaded straight from the port; later reloads use the latched copy
    assign pat_d   = (state_q == IDLE && bus.start) ? bus.pat_in : pat_q;
    assign pat_src = (state_q == IDLE) ? bus.pat_in : pat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat_q <= PATTERN;
        else        pat_q <= pat_d;
    end
`else
    assign pat_src = PATTERN;
`endif
    seq_shift #(.W(PAT_W)) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (pat_src),
        .msb   (msb)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            d_out_q <= 1'b0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
        end
    end
    // state_q/idx_q describe the bit currently on the outputs; *_d describe the next one
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                rem_d = bus.repeat_cnt;
                gap_d = bus.gap;
                idx_d = IDX_W'(PAT_W - 1);
                if (bus.repeat_cnt != '0) begin
                    state_d = PAT;
                    load    = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            PAT: if (bus.abort) begin
                state_d = IDLE;
            end else if (idx_q != '0) begin
                idx_d = idx_q - IDX_W'(1);
                shift = 1'b1;
            end else begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_q == '0) begin
                    idx_d = IDX_W'(PAT_W - 1);
                    load  = 1'b1;
                end else begin
                    state_d = GAP;
                    gcnt_d  = gap_q;
                end
            end
            GAP: if (bus.abort) begin
                state_d = IDLE;
            end else if (gcnt_q == GAP_W'(1)) begin
                state_d = PAT;
                idx_d   = IDX_W'(PAT_W - 1);
                load    = 1'b1;
            end else begin
                gcnt_d = gcnt_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        valid_d = state_d != IDLE;
        d_out_d = (state_d == PAT) & msb;
        fe_d    = (state_d == PAT) && (idx_d == '0);
    end
    assign bus.d_out     = d_out_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = valid_q;
    assign bus.frame_end = fe_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: table-driven bursts plus hand-written abort/reset/back-to-back sequences for seq_gen
module tb_seq_gen;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    seq_gen_if #(.CNT_W(8), .GAP_W(4)) bus ();
    seq_gen u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] rep;
        logic [3:0] gap;
        bit         poke;
        string      bits;
        string      fe;
    } vec_t;
    vec_t tbl[7];
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask
    task automatic chks(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=\"%s\" expected=\"%s\"", name, act, exp);
        end
    endtask
    // Starts a burst, then records the VALID-cycle stream until DONE (bounded). n_done is the
    // number of cycles after the START edge at which DONE was seen, or -1 on timeout.
    task automatic run_burst(input logic [7:0] rep, input logic [3:0] g, input bit poke,
                             output string bits, output string fe, output int n_done, output int odd);
        int cyc;
        bits = "";
        fe = "";
        odd = 0;
        cyc = 0;
        bus.start = 1'b1;
        bus.repeat_cnt = rep;
        bus.gap = g;
        tick;
        bus.start = 1'b0;
        bus.repeat_cnt = 8'hFF;
        bus.gap = 4'hF;
        while (!bus.done && cyc < 300) begin
            if (bus.valid) begin
                bits = {bits, (bus.d_out ? "1" : "0")};
                fe = {fe, (bus.frame_end ? "F" : ".")};
            end
            if (bus.busy !== bus.valid || (bus.frame_end && !bus.valid) || (bus.d_out && !bus.valid)) odd++;
            bus.start = poke && (cyc == 3 || cyc == 4);
            tick;
            cyc++;
        end
        bus.start = 1'b0;
        n_done = bus.done ? cyc : -1;
    endtask
    initial begin
        string bits, fe;
        int    n_done, odd, seen;
        tbl[0] = '{8'd1, 4'd0, 1'b0, "10101011", ".......F"};
        tbl[1] = '{8'd2, 4'd0, 1'b0, "1010101110101011", ".......F.......F"};
        tbl[2] = '{8'd3, 4'd2, 1'b0, "1010101100101010110010101011", ".......F.........F.........F"};
        tbl[3] = '{8'd2, 4'd1, 1'b1, "10101011010101011", ".......F........F"};
        tbl[4] = '{8'd1, 4'd5, 1'b0, "10101011", ".......F"};
        tbl[5] = '{8'd0, 4'd3, 1'b0, "", ""};
        tbl[6] = '{8'd2, 4'd3, 1'b0, "1010101100010101011", ".......F..........F"};
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.repeat_cnt = '0;
        bus.gap = '0;
`ifdef SEQ_GEN_PROG_PAT_EN
        bus.pat_in = 8'b10101011;
`endif
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #10;
        chk("reset_outputs", {bus.d_out, bus.valid, bus.frame_end, bus.busy, bus.done}, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("idle_after_reset", {bus.d_out, bus.valid, bus.frame_end, bus.busy, bus.done}, 0);
        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i].rep, tbl[i].gap, tbl[i].poke, bits, fe, n_done, odd);
            chks($sformatf("stream%0d", i), bits, tbl[i].bits);
            chks($sformatf("frame_end%0d", i), fe, tbl[i].fe);
            chk($sformatf("done_cycle%0d", i), n_done, tbl[i].bits.len());
            chk($sformatf("busy_valid%0d", i), odd, 0);
            chk($sformatf("idle_at_done%0d", i), {bus.valid, bus.busy}, 0);
            tick;
            chk($sformatf("done_pulse%0d", i), bus.done, 0);
        end
        // START and ABORT together in IDLE: START wins; then START held in the DONE cycle
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.repeat_cnt = 8'd1;
        bus.gap = 4'd0;
        tick;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_beats_abort", {bus.valid, bus.d_out}, 2'b11);
        repeat (8) tick;
        chk("done_before_b2b", {bus.done, bus.valid}, 2'b10);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("back_to_back", {bus.valid, bus.d_out, bus.done}, 3'b110);
        repeat (8) tick;
        chk("b2b_done", bus.done, 1);
        tick;
        // ABORT on the 5th bit of frame 2 of a 4-frame burst
        bus.start = 1'b1;
        bus.repeat_cnt = 8'd4;
        bus.gap = 4'd0;
        tick;
        bus.start = 1'b0;
        repeat (12) tick;
        chk("abort_bit", {bus.valid, bus.d_out, bus.frame_end}, 3'b110);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("abort_idle", {bus.valid, bus.busy, bus.d_out}, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            seen += int'(bus.done) + int'(bus.valid);
            tick;
        end
        chk("abort_no_done", seen, 0);
        // ABORT inside a gap
        bus.start = 1'b1;
        bus.repeat_cnt = 8'd2;
        bus.gap = 4'd3;
        tick;
        bus.start = 1'b0;
        repeat (8) tick;
        chk("in_gap", {bus.valid, bus.busy, bus.d_out}, 3'b110);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("gap_abort", {bus.valid, bus.busy, bus.done}, 0);
        tick;
        chk("gap_abort_no_done", {bus.valid, bus.done}, 0);
        // Asynchronous reset at pattern index 3
        bus.start = 1'b1;
        bus.repeat_cnt = 8'd2;
        bus.gap = 4'd0;
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        chk("pre_reset_bit", {bus.valid, bus.d_out}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.d_out, bus.valid, bus.frame_end, bus.busy, bus.done}, 0);
        tick;
        rst_n = 1'b1;
        tick;
        run_burst(8'd1, 4'd0, 1'b0, bits, fe, n_done, odd);
        chks("post_reset_stream", bits, "10101011");
        chk("post_reset_done", n_done, 8);
        tick;
`ifdef SEQ_GEN_PROG_PAT_EN
        bus.pat_in = 8'hC3;
        bus.start = 1'b1;
        bus.repeat_cnt = 8'd2;
        bus.gap = 4'd1;
        tick;
        bus.start = 1'b0;
        bus.pat_in = 8'h00;
        bits = "";
        for (int i = 0; i < 17; i++) begin
            bits = {bits, (bus.d_out ? "1" : "0")};
            tick;
        end
        chks("prog_pattern", bits, "11000011011000011");
        chk("prog_done", bus.done, 1);
        tick;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
